// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding,
// fetch FSM state encoding and the redirect-priority selector.
package if_fetch_pkg;

  // addi x0,x0,0 -- placed in IF/ID whenever it carries no real instruction
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } redirect_t;

  // Trap beats resolved branch beats early branch; target forced word aligned.
  function automatic redirect_t redirect_sel(
    input logic        trap_v,
    input logic [31:0] trap_pc,
    input logic        br_v,
    input logic [31:0] br_pc,
    input logic        early_v,
    input logic [31:0] early_pc
  );
    redirect_t r;
    r.valid = trap_v | br_v | early_v;
    if (trap_v)    r.target = trap_pc;
    else if (br_v) r.target = br_pc;
    else           r.target = early_pc;
    r.target[1:0] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for an instruction that arrives while decode
// is stalled. Clear wins over load.
module if_hold_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  // Occupancy flag: the only state that must be defined out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         full_q <= 1'b0;
    else if (clear_i) full_q <= 1'b0;
    else if (load_i)  full_q <= 1'b1;
  end

  // Payload is only meaningful while full_q is set
  always_ff @(posedge clk) begin
    if (load_i) data_q <= data_i;
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: owns the fetch PC, runs a single-outstanding
// request/grant/response protocol to instruction memory and fills IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_fetch_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        redirect_trap,
  input  logic [31:0] trap_pc,
  input  logic        redirect_br,
  input  logic [31:0] br_pc,
  input  logic        redirect_early,
  input  logic [31:0] early_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        if_valid
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_inc;
  redirect_t    rd;

  logic         deliver_wait, deliver_hold;
  logic         buf_load, buf_clear, buf_full;
  logic [31:0]  buf_data;

  logic [31:0]  pc_id_q, pcp4_id_q, inst_id_q;
  logic         vld_id_q;
  logic [31:0]  pc_id_d, pcp4_id_d, inst_id_d;
  logic         vld_id_d;

  assign rd     = redirect_sel(redirect_trap, trap_pc, redirect_br, br_pc,
                               redirect_early, early_pc);
  assign pc_inc = pc_q + 32'd4;

  // A response reaches decode either straight from memory or from the buffer
  assign deliver_wait = (state_q == S_WAIT) && imem_rvalid && !keep && !rd.valid;
  assign deliver_hold = (state_q == S_HOLD) && buf_full && !keep && !rd.valid;
  assign buf_load     = (state_q == S_WAIT) && imem_rvalid && keep && !rd.valid;
  assign buf_clear    = (state_q == S_HOLD) && (rd.valid || !keep);

  if_hold_buf #(.W(32)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .clear_i (buf_clear),
    .data_i  (imem_rdata),
    .data_o  (buf_data),
    .full_o  (buf_full)
  );

  // Request issue; the next request goes out in the same cycle a response is
  // consumed so a same-cycle-grant memory sustains one instruction per cycle
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      S_REQ:   imem_req = 1'b1;
      S_WAIT: begin
        if (deliver_wait) begin
          imem_req  = 1'b1;
          imem_addr = pc_inc;
        end
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch FSM and architectural fetch PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd.valid) pc_q <= rd.target;
          state_q <= S_REQ;
        end
        S_REQ: begin
          if (rd.valid) pc_q <= rd.target;
          if (imem_gnt) state_q <= rd.valid ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (rd.valid) begin
              pc_q    <= rd.target;
              state_q <= S_REQ;
            end else if (keep) begin
              state_q <= S_HOLD;
            end else begin
              pc_q    <= pc_inc;
              state_q <= imem_gnt ? S_WAIT : S_REQ;
            end
          end else if (rd.valid) begin
            pc_q    <= rd.target;
            state_q <= S_DROP;
          end
        end
        S_HOLD: begin
          if (rd.valid) begin
            pc_q    <= rd.target;
            state_q <= S_REQ;
          end else if (!keep) begin
            pc_q    <= pc_inc;
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          if (rd.valid)    pc_q    <= rd.target;
          if (imem_rvalid) state_q <= S_REQ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // IF/ID next value: flush beats stall, stall holds, otherwise load or bubble
  always_comb begin
    pc_id_d   = pc_id_q;
    pcp4_id_d = pcp4_id_q;
    inst_id_d = inst_id_q;
    vld_id_d  = vld_id_q;
    if (rd.valid) begin
      inst_id_d = NOP_INST;
      vld_id_d  = 1'b0;
    end else if (!keep) begin
      if (deliver_wait || deliver_hold) begin
        pc_id_d   = pc_q;
        pcp4_id_d = pc_inc;
        inst_id_d = deliver_wait ? imem_rdata : buf_data;
        vld_id_d  = 1'b1;
      end else begin
        inst_id_d = NOP_INST;
        vld_id_d  = 1'b0;
      end
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_id_q   <= 32'h0;
      pcp4_id_q <= 32'h0;
      inst_id_q <= NOP_INST;
      vld_id_q  <= 1'b0;
    end else begin
      pc_id_q   <= pc_id_d;
      pcp4_id_q <= pcp4_id_d;
      inst_id_q <= inst_id_d;
      vld_id_q  <= vld_id_d;
    end
  end

  assign PC_pype0         = pc_id_q;
  assign PCp4_pype0       = pcp4_id_q;
  assign Instraction_pype = inst_id_q;
  assign if_valid         = vld_id_q;

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: a small instruction memory (rdata = addr ^ A5A5_0000,
// 1- or 2-cycle response latency) plus a scoreboard of expected fetch PCs.
module tb_if_fetch;

  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        keep = 1'b0;
  logic        redirect_trap = 1'b0, redirect_br = 1'b0, redirect_early = 1'b0;
  logic [31:0] trap_pc = '0, br_pc = '0, early_pc = '0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype;
  logic        if_valid;

  // memory A controls
  logic        gnt_en = 1'b1, lat2 = 1'b0, inj_rvalid = 1'b0;
  logic [31:0] inj_rdata = '0;
  logic        s1_v = 1'b0, s2_v = 1'b0;
  logic [31:0] s1_a = '0, s2_a = '0;

  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = inj_rvalid | (lat2 ? s2_v : s1_v);
  assign imem_rdata  = inj_rvalid ? inj_rdata : ((lat2 ? s2_a : s1_a) ^ K);

  always @(posedge clk) begin
    s1_v <= imem_req & imem_gnt;
    s1_a <= imem_addr;
    s2_v <= s1_v;
    s2_a <= s1_a;
  end

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .keep(keep),
    .redirect_trap(redirect_trap), .trap_pc(trap_pc),
    .redirect_br(redirect_br), .br_pc(br_pc),
    .redirect_early(redirect_early), .early_pc(early_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0),
    .Instraction_pype(Instraction_pype), .if_valid(if_valid)
  );

  // second instance: reset PC at the top of the address space
  logic        b_req, b_rvalid = 1'b0, b_valid;
  logic [31:0] b_addr, b_a = '0, b_pc, b_pcp4, b_inst;
  always @(posedge clk) begin
    b_rvalid <= b_req;
    b_a      <= b_addr;
  end

  if_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .keep(1'b0),
    .redirect_trap(1'b0), .trap_pc(32'h0),
    .redirect_br(1'b0), .br_pc(32'h0),
    .redirect_early(1'b0), .early_pc(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_req),
    .imem_rvalid(b_rvalid), .imem_rdata(b_a ^ K),
    .PC_pype0(b_pc), .PCp4_pype0(b_pcp4),
    .Instraction_pype(b_inst), .if_valid(b_valid)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // scoreboard: a valid IF/ID after an edge without stall or redirect is a new load
  logic keep_e = 1'b0, redir_e = 1'b0;
  always @(posedge clk) begin
    keep_e  <= keep;
    redir_e <= redirect_trap | redirect_br | redirect_early;
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst && if_valid && !keep_e && !redir_e) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got PC %h, required no instruction", PC_pype0);
      end else begin
        e = exp_q.pop_front();
        if (PC_pype0 !== e || PCp4_pype0 !== e + 32'd4 || Instraction_pype !== (e ^ K)) begin
          errors++;
          $display("FAIL sb_order: got PC %h PCp4 %h inst %h, required PC %h PCp4 %h inst %h",
                   PC_pype0, PCp4_pype0, Instraction_pype, e, e + 32'd4, e ^ K);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", imem_req); end
    checks++; if (PC_pype0 !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h required 0", PC_pype0); end
    checks++; if (PCp4_pype0 !== 32'h0) begin errors++; $display("FAIL rst_pcp4: got %h required 0", PCp4_pype0); end
    checks++; if (Instraction_pype !== NOP) begin errors++; $display("FAIL rst_inst: got %h required %h", Instraction_pype, NOP); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", if_valid); end
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b required 0", imem_req); end
  endtask

  task automatic test_stream();
    step();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req: got %b/%h required 1/0", imem_req, imem_addr); end
    checks++; if (b_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first_addr: got %h required fffffffc", b_addr); end
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL b2b_req: got %b/%h required 1/4", imem_req, imem_addr); end
    checks++; if (b_addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h required 0", b_addr); end
    step();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h0 || PCp4_pype0 !== 32'h4 || Instraction_pype !== K)
      begin errors++; $display("FAIL first_inst: got v%b %h %h %h required v1 0 4 %h", if_valid, PC_pype0, PCp4_pype0, Instraction_pype, K); end
    checks++; if (b_valid !== 1'b1 || b_pc !== 32'hFFFF_FFFC || b_pcp4 !== 32'h0)
      begin errors++; $display("FAIL wrap_pcp4: got v%b %h %h required v1 fffffffc 0", b_valid, b_pc, b_pcp4); end
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 3) gnt_en = 1'b0;
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'(4 * i))
        begin errors++; $display("FAIL stream_%0d: got v%b %h required v1 %h", i, if_valid, PC_pype0, 32'(4 * i)); end
    end
    step();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h14)
      begin errors++; $display("FAIL stream_park: got v%b %h req%b %h required v1 10 req1 14", if_valid, PC_pype0, imem_req, imem_addr); end
    checks++; if (b_pc !== 32'hC) begin errors++; $display("FAIL wrap_stream: got %h required c", b_pc); end
  endtask

  task automatic test_keep();
    step();
    gnt_en = 1'b1;
    exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    step();
    step();
    keep = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL keep_noissue: got %b required 0", imem_req); end
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        step();
        if (k == 3) keep = 1'b0;
        @(negedge clk);
      end
      checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h14 || Instraction_pype !== (32'h14 ^ K))
        begin errors++; $display("FAIL keep_frozen_%0d: got v%b %h %h required v1 14 %h", k, if_valid, PC_pype0, Instraction_pype, 32'h14 ^ K); end
    end
    step();
    gnt_en = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h18) begin errors++; $display("FAIL keep_release: got v%b %h required v1 18", if_valid, PC_pype0); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C) begin errors++; $display("FAIL keep_next: got %b/%h required 1/1c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect();
    step();
    redirect_early = 1'b1; early_pc = 32'h8;
    step();
    redirect_early = 1'b0; gnt_en = 1'b1; lat2 = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL early_addr: got %b/%h required 1/8", imem_req, imem_addr); end
    step();
    redirect_br = 1'b1; br_pc = 32'h100;
    step();
    redirect_br = 1'b0;
    exp_q.push_back(32'h100);
    @(negedge clk);
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL drop_stale: got v%b req%b required v0 req0", if_valid, imem_req); end
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0)
      begin errors++; $display("FAIL br_refetch: got req%b %h v%b required req1 100 v0", imem_req, imem_addr, if_valid); end
    step();
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_bubble: got %b required 0", if_valid); end
    step();
    gnt_en = 1'b0;
    step();
    lat2 = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h100 || imem_addr !== 32'h104)
      begin errors++; $display("FAIL br_target: got v%b %h next %h required v1 100 104", if_valid, PC_pype0, imem_addr); end
  endtask

  task automatic test_priority();
    step();
    gnt_en = 1'b1;
    exp_q.push_back(32'h200);
    step();
    redirect_trap = 1'b1; trap_pc = 32'h200;
    redirect_br = 1'b1; br_pc = 32'h300;
    redirect_early = 1'b1; early_pc = 32'h400;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL prio_discard: got req %b required 0", imem_req); end
    step();
    redirect_trap = 1'b0; redirect_br = 1'b0; redirect_early = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || if_valid !== 1'b0)
      begin errors++; $display("FAIL prio_trap: got req%b %h v%b required req1 200 v0", imem_req, imem_addr, if_valid); end
    step();
    gnt_en = 1'b0;
    step();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h200 || PCp4_pype0 !== 32'h204)
      begin errors++; $display("FAIL prio_load: got v%b %h %h required v1 200 204", if_valid, PC_pype0, PCp4_pype0); end
  endtask

  task automatic test_misaligned();
    step();
    redirect_early = 1'b1; early_pc = 32'h0000_0106;
    step();
    redirect_early = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || if_valid !== 1'b0)
      begin errors++; $display("FAIL align: got req%b %h v%b required req1 104 v0", imem_req, imem_addr, if_valid); end
    step();
    redirect_br = 1'b1; br_pc = 32'h300;
    redirect_early = 1'b1; early_pc = 32'h400;
    step();
    redirect_br = 1'b0; redirect_early = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h300) begin errors++; $display("FAIL prio_br: got %h required 300", imem_addr); end
  endtask

  task automatic test_reset_mid();
    step();
    gnt_en = 1'b1; lat2 = 1'b1;
    step();
    rst = 1'b0; gnt_en = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || PC_pype0 !== 32'h0 || Instraction_pype !== NOP)
      begin errors++; $display("FAIL async_rst: got req%b v%b %h %h required req0 v0 0 %h", imem_req, if_valid, PC_pype0, Instraction_pype, NOP); end
    step();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || PC_pype0 !== 32'h0 || PCp4_pype0 !== 32'h0 || Instraction_pype !== NOP)
      begin errors++; $display("FAIL rst_ignore_rvalid: got req%b v%b %h %h %h required req0 v0 0 0 %h", imem_req, if_valid, PC_pype0, PCp4_pype0, Instraction_pype, NOP); end
    step();
    rst = 1'b1; lat2 = 1'b0; gnt_en = 1'b1;
    inj_rvalid = 1'b1; inj_rdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_rvalid_req: got %b required 0", imem_req); end
    step();
    inj_rvalid = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0)
      begin errors++; $display("FAIL idle_rvalid_ignored: got req%b %h v%b required req1 0 v0", imem_req, imem_addr, if_valid); end
    step();
    gnt_en = 1'b0;
    step();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || PC_pype0 !== 32'h0 || Instraction_pype !== K)
      begin errors++; $display("FAIL rst_restart: got v%b %h %h required v1 0 %h", if_valid, PC_pype0, Instraction_pype, K); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_keep();
    test_redirect();
    test_priority();
    test_misaligned();
    test_reset_mid();
    step(); step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the decode stage.
- Owns the architectural fetch PC and drives an instruction-memory request/grant/response interface, with at most one request outstanding.
- Fills the IF/ID pipeline register (PC_pype0, PCp4_pype0, Instraction_pype) and marks bubbles via if_valid.
- Handles stall (keep), redirects from trap/branch/early-branch, and discards stale responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction placed in IF/ID on bubble or flush (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- keep  in  1  stall: hold IF/ID register and do not advance the PC.
- redirect_trap  in  1  trap/ecall/mret redirect valid.
- trap_pc  in  32  trap target.
- redirect_br  in  1  resolved-branch redirect valid.
- br_pc  in  32  branch target.
- redirect_early  in  1  early-branch redirect valid from decode.
- early_pc  in  32  early-branch target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- PC_pype0  out  32  PC of the instruction in IF/ID.
- PCp4_pype0  out  32  PC_pype0+4.
- Instraction_pype  out  32  instruction in IF/ID.
- if_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- Reset (async, rst=0):
  - pc_q=RESET_PC; state=S_IDLE; buffer empty.
  - PC_pype0=0, PCp4_pype0=0, Instraction_pype=NOP_INST, if_valid=0, imem_req=0.
  - A reset mid-transaction abandons it; any later rvalid is ignored while in S_IDLE.
- Redirect:
  - Priority: trap > br > early.
  - Target is written to pc_q with bits[1:0] forced to 0.
  - Any redirect flushes IF/ID (NOP_INST, if_valid=0). Flush overrides keep.
- States:
  - S_IDLE: imem_req=0; go to S_REQ next cycle.
  - S_REQ: imem_req=1, imem_addr=pc_q.
    - gnt && !redirect: go to S_WAIT.
    - gnt && redirect: go to S_DROP; pc_q=target.
    - !gnt && redirect: pc_q=target, stay in S_REQ. imem_addr may change while ungranted.
  - S_WAIT (one request outstanding):
    - rvalid && redirect: discard data, pc_q=target, go to S_REQ.
    - rvalid && keep: capture imem_rdata into the 1-entry hold buffer, go to S_HOLD.
    - rvalid && !keep: load IF/ID (PC=pc_q, PCp4=pc_q+4, inst=rdata, if_valid=1) and set pc_q=pc_q+4.
      - Back-to-back issue: imem_req=1 combinationally, imem_addr=pc_q+4.
      - gnt: stay in S_WAIT. !gnt: go to S_REQ.
    - No rvalid, redirect: go to S_DROP, pc_q=target.
  - S_HOLD:
    - redirect: drop the buffer, go to S_REQ.
    - !keep: load IF/ID from the buffer, pc_q+=4, go to S_REQ.
  - S_DROP: discard the next rvalid, then go to S_REQ. A further redirect here only updates pc_q.
- IF/ID update rules:
  - When !keep and no data is delivered, IF/ID loads a bubble (NOP_INST, if_valid=0). PC/PCp4 keep their previous values.
  - When keep && !redirect, IF/ID holds.
- Arithmetic: 32-bit modulo adds. PC 0xFFFF_FFFC gives PCp4 0x0000_0000.
- Throughput: 1 instruction/cycle when gnt is same-cycle and rvalid arrives the cycle after gnt.
- Decode-visible latency: IF/ID updates on the edge ending the rvalid cycle.
- imem_rvalid outside S_WAIT/S_DROP is ignored.

Decomposition:
- Shared package: NOP_INST, the state encoding (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP), and the redirect-priority select function.
- Sub-module if_hold_buf: 1-entry holding register with load/clear/full.

Test Plan:
- Reset release, memory with same-cycle gnt and 1-cycle rvalid, rdata=addr^0xA5A5_0000 → first if_valid=1 at PC 0x0, then PC 0x4, 0x8, 0xC on consecutive cycles.
- keep held 3 cycles during S_WAIT, rvalid arriving in its first cycle → IF/ID frozen; the instruction appears one cycle after keep drops; no address is skipped or repeated.
- redirect_br to 0x100 while a request to 0x8 is outstanding → the 0x8 response is discarded; the next request is 0x100; if_valid=0 until the 0x100 response arrives.
- Same cycle: redirect_trap=1 (0x200), redirect_br=1 (0x300), redirect_early=1 (0x400) → next imem_addr=0x200.
- early_pc=0x0000_0106 → imem_addr=0x0000_0104.
- RESET_PC=0xFFFF_FFFC → PC_pype0=0xFFFF_FFFC, PCp4_pype0=0x0, next fetch at 0x0.
- Assert rst low while in S_WAIT, then deliver rvalid → the response is ignored and all outputs are at reset values.
